msb_pos_pipe: RTL and testbench

MSB_POS_PIPE -- requirements
Module: msb_pos_pipe

---
 rtl/msb_pos_pipe.sv | 105 ++++++++++
 tb/tb_msb_pos_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msb_pos_pipe.sv
// msb_pos_pipe -- two-stage pipelined highest/lowest set-bit locator.
//
// Stage 1 finds, per GRP-bit group, the 1-based local position of the
// highest (mode 0) or lowest (mode 1) set bit. Stage 2 picks the highest
// or lowest non-empty group and forms the global 1-based position.
// The two stages use a valid/ready handshake and can each hold one word.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   in_valid   upstream word present
//   in_ready   word accepted this cycle (depends on out_ready, not in_valid)
//   data       word to search
//   mode       0 = highest set bit, 1 = lowest set bit
//   out_valid  result present
//   out_ready  downstream accepts result
//   pos        1-based bit position, 0 when no bit set
//   zero       searched word was all zeros
module msb_pos_pipe #(
   parameter int DW_IN = 64,
   parameter int GRP   = 8,
   localparam int NG    = DW_IN / GRP,
   localparam int POS_W = $clog2(DW_IN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW_IN-1:0] data,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [POS_W-1:0] pos,
   output logic             zero
);

   localparam int LW = $clog2(GRP + 1);

   logic                   s1_valid;
   logic                   s1_mode;
   logic [NG-1:0][LW-1:0]  s1_loc;
   logic [NG-1:0][LW-1:0]  loc_d;
   logic [POS_W-1:0]       pos_d;
   logic                   any_d;
   logic                   adv1;
   logic                   adv2;

   assign adv2     = !out_valid || out_ready;
   assign adv1     = !s1_valid || adv2;
   assign in_ready = adv1;

   // Scan order is flipped by mode so that "last hit wins" always yields
   // the wanted bit: ascending for highest, descending for lowest.
   always_comb begin
      loc_d = '0;
      for (int g = 0; g < NG; g++) begin
         for (int i = 0; i < GRP; i++) begin
            int bi;
            bi = mode ? (GRP - 1 - i) : i;
            if (data[g*GRP + bi]) loc_d[g] = LW'(bi + 1);
         end
      end
   end

   // Same last-hit-wins trick across groups.
   always_comb begin
      pos_d = '0;
      any_d = 1'b0;
      for (int g = 0; g < NG; g++) begin
         int gi;
         gi = s1_mode ? (NG - 1 - g) : g;
         if (s1_loc[gi] != '0) begin
            pos_d = POS_W'(gi * GRP) + POS_W'(s1_loc[gi]);
            any_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
         pos       <= '0;
         zero      <= 1'b0;
      end else begin
         if (adv1) s1_valid <= in_valid;
         if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               pos  <= pos_d;
               zero <= !any_d;
            end
         end
      end
   end

   // Payload registers carry no reset; s1_valid qualifies them.
   always_ff @(posedge clk) begin
      if (adv1 && in_valid) begin
         s1_loc  <= loc_d;
         s1_mode <= mode;
      end
   end

endmodule

// File: tb/tb_msb_pos_pipe.sv
module tb_msb_pos_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // instance A: default parameters
   logic        a_in_valid, a_in_ready, a_mode, a_out_valid, a_out_ready, a_zero;
   logic [63:0] a_data;
   logic [6:0]  a_pos;
   // instance B: DW_IN = 32, GRP = 4
   logic        b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready, b_zero;
   logic [31:0] b_data;
   logic [5:0]  b_pos;

   msb_pos_pipe dut_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .data(a_data), .mode(a_mode), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .pos(a_pos), .zero(a_zero));

   msb_pos_pipe #(.DW_IN(32), .GRP(4)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .data(b_data), .mode(b_mode), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .pos(b_pos), .zero(b_zero));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // reference: scan every bit of the word, no grouping
   function automatic int ref_pos(input logic [255:0] d, input int w, input logic m);
      int r;
      r = 0;
      for (int i = 0; i < w; i++) begin
         if (d[i]) begin
            if (!m) r = i + 1;
            else if (r == 0) r = i + 1;
         end
      end
      return r;
   endfunction

   function automatic logic [255:0] gen_data(input int w);
      logic [255:0] d;
      int k;
      k = int'($urandom_range(0, 3));
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
      case (k)
         1: begin d = '0; d[$urandom_range(0, w - 1)] = 1'b1; end
         2: d = '0;
         3: for (int i = 0; i < 8; i++) d[i*32 +: 32] = d[i*32 +: 32] & $urandom & $urandom;
         default: ;
      endcase
      for (int i = w; i < 256; i++) d[i] = 1'b0;
      return d;
   endfunction

   // scoreboards for the random phase
   bit mon_en = 1'b0;
   int qa[$];
   int qb[$];
   int na_in = 0, na_out = 0, nb_in = 0, nb_out = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (a_out_valid) begin
            if (qa.size() == 0) begin
               checks++; errors++;
               $display("FAIL a_spurious actual=out_valid required=no_result t=%0t", $time);
            end else begin
               chk("a_pos", 64'(a_pos), 64'(qa[0]));
               chk("a_zero", 64'(a_zero), 64'(qa[0] == 0));
               if (a_out_ready) begin void'(qa.pop_front()); na_out++; end
            end
         end
         if (a_in_valid && a_in_ready) begin
            qa.push_back(ref_pos(256'(a_data), 64, a_mode));
            na_in++;
         end
         if (b_out_valid) begin
            if (qb.size() == 0) begin
               checks++; errors++;
               $display("FAIL b_spurious actual=out_valid required=no_result t=%0t", $time);
            end else begin
               chk("b_pos", 64'(b_pos), 64'(qb[0]));
               chk("b_zero", 64'(b_zero), 64'(qb[0] == 0));
               if (b_out_ready) begin void'(qb.pop_front()); nb_out++; end
            end
         end
         if (b_in_valid && b_in_ready) begin
            qb.push_back(ref_pos(256'(b_data), 32, b_mode));
            nb_in++;
         end
      end
   end

   typedef struct {
      logic [63:0] data;
      logic        mode;
      int          pos;
      logic        zero;
   } vec_t;

   vec_t tv[14];

   initial begin
      tv[0]  = '{64'h8000_0000_0000_0000, 1'b0, 64, 1'b0};
      tv[1]  = '{64'h8000_0000_0000_0000, 1'b1, 64, 1'b0};
      tv[2]  = '{64'h0000_0000_0000_0001, 1'b0,  1, 1'b0};
      tv[3]  = '{64'h0000_0000_0000_0001, 1'b1,  1, 1'b0};
      tv[4]  = '{64'h0000_0000_0000_0000, 1'b0,  0, 1'b1};
      tv[5]  = '{64'h0000_0000_0000_0000, 1'b1,  0, 1'b1};
      tv[6]  = '{64'h0000_0100_0000_8000, 1'b0, 41, 1'b0};
      tv[7]  = '{64'h0000_0100_0000_8000, 1'b1, 16, 1'b0};
      tv[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64, 1'b0};
      tv[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1,  1, 1'b0};
      tv[10] = '{64'h0000_0000_0000_0080, 1'b0,  8, 1'b0};
      tv[11] = '{64'h0000_0000_0000_0080, 1'b1,  8, 1'b0};
      tv[12] = '{64'h0000_0000_0000_0180, 1'b0,  9, 1'b0};
      tv[13] = '{64'h0000_0000_0000_0180, 1'b1,  8, 1'b0};

      a_in_valid = 0; a_data = '0; a_mode = 0; a_out_ready = 1;
      b_in_valid = 0; b_data = '0; b_mode = 0; b_out_ready = 1;

      // reset state
      step(); step();
      chk("rst_out_valid", 64'(a_out_valid), 0);
      chk("rst_pos", 64'(a_pos), 0);
      chk("rst_zero", 64'(a_zero), 0);
      rst = 0;
      #1;
      chk("rst_in_ready", 64'(a_in_ready), 1);

      // single words, exact 2-cycle latency
      for (int i = 0; i < 14; i++) begin
         a_in_valid = 1; a_data = tv[i].data; a_mode = tv[i].mode; a_out_ready = 1;
         step();
         a_in_valid = 0;
         chk($sformatf("tv%0d_lat", i), 64'(a_out_valid), 0);
         step();
         chk($sformatf("tv%0d_valid", i), 64'(a_out_valid), 1);
         chk($sformatf("tv%0d_pos", i), 64'(a_pos), 64'(tv[i].pos));
         chk($sformatf("tv%0d_zero", i), 64'(a_zero), 64'(tv[i].zero));
      end
      step();

      // back-to-back: 1 then 0
      a_in_valid = 1; a_mode = 0; a_data = 64'h1;
      step();
      a_data = 64'h0;
      step();
      a_in_valid = 0;
      chk("b2b_v1", 64'(a_out_valid), 1);
      chk("b2b_pos1", 64'(a_pos), 1);
      chk("b2b_zero1", 64'(a_zero), 0);
      step();
      chk("b2b_v2", 64'(a_out_valid), 1);
      chk("b2b_pos2", 64'(a_pos), 0);
      chk("b2b_zero2", 64'(a_zero), 1);
      step();
      chk("b2b_drain", 64'(a_out_valid), 0);

      // same word both modes back-to-back
      a_in_valid = 1; a_data = 64'h0000_0100_0000_8000; a_mode = 0;
      step();
      a_mode = 1;
      step();
      a_in_valid = 0;
      chk("mix_pos1", 64'(a_pos), 41);
      step();
      chk("mix_pos2", 64'(a_pos), 16);
      step();

      // stall: 3 words offered, 2 accepted, mode flipped while stalled
      a_out_ready = 0;
      a_in_valid = 1; a_data = 64'h8000_0000_0000_0000; a_mode = 0;
      step();
      a_data = 64'h0000_0100_0000_8000; a_mode = 1;
      step();
      a_mode = 0;
      chk("stall_valid", 64'(a_out_valid), 1);
      chk("stall_pos", 64'(a_pos), 64);
      chk("stall_in_ready", 64'(a_in_ready), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_hold_pos", 64'(a_pos), 64);
         chk("stall_hold_valid", 64'(a_out_valid), 1);
         chk("stall_hold_rdy", 64'(a_in_ready), 0);
      end
      a_out_ready = 1;
      #1;
      chk("unstall_in_ready", 64'(a_in_ready), 1);
      step();
      a_in_valid = 0;
      chk("unstall_w2", 64'(a_pos), 16);
      chk("unstall_w2_v", 64'(a_out_valid), 1);
      step();
      chk("unstall_w3", 64'(a_pos), 41);
      chk("unstall_w3_v", 64'(a_out_valid), 1);
      step();
      chk("unstall_empty", 64'(a_out_valid), 0);

      // reset with two words in flight
      a_in_valid = 1; a_data = 64'h0; a_mode = 0;
      step();
      a_data = 64'h0000_0000_0000_0010;
      step();
      a_in_valid = 0;
      chk("pre_rst_valid", 64'(a_out_valid), 1);
      chk("pre_rst_zero", 64'(a_zero), 1);
      rst = 1;
      #1;
      chk("arst_valid", 64'(a_out_valid), 0);
      chk("arst_pos", 64'(a_pos), 0);
      chk("arst_zero", 64'(a_zero), 0);
      step();
      rst = 0;
      #1;
      chk("post_rst_rdy", 64'(a_in_ready), 1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_rst_stale", 64'(a_out_valid), 0);
      end

      // random sweep, both instances, random stalls on both sides
      mon_en = 1;
      fork
         begin
            for (int c = 0; c < 3000; c++) begin
               logic [255:0] d;
               d = gen_data(64);
               a_in_valid  = ($urandom_range(0, 9) < 7);
               a_data      = d[63:0];
               a_mode      = 1'($urandom_range(0, 1));
               a_out_ready = ($urandom_range(0, 9) < 6);
               step();
            end
            a_in_valid = 0; a_out_ready = 1;
         end
         begin
            for (int c = 0; c < 3000; c++) begin
               logic [255:0] d;
               d = gen_data(32);
               b_in_valid  = ($urandom_range(0, 9) < 7);
               b_data      = d[31:0];
               b_mode      = 1'($urandom_range(0, 1));
               b_out_ready = ($urandom_range(0, 9) < 6);
               step();
            end
            b_in_valid = 0; b_out_ready = 1;
         end
      join
      repeat (10) step();
      mon_en = 0;
      chk("a_count", 64'(na_out), 64'(na_in));
      chk("a_left", 64'(qa.size()), 0);
      chk("b_count", 64'(nb_out), 64'(nb_in));
      chk("b_left", 64'(qb.size()), 0);
      chk("a_some_traffic", 64'(na_in > 500), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
